// File: rtl/bus_pkg.sv
// Shared types and helpers for the bus transaction controller slice.
package bus_pkg;

  localparam int DEF_NUM_MASTERS    = 4;
  localparam int DEF_ADDR_WIDTH     = 16;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Index of the lowest set bit; scanning downwards lets the lowest index win on multi-hot input.
  function automatic logic [7:0] onehot_to_idx(input logic [63:0] vec);
    logic [7:0] idx;
    idx = 8'd0;
    for (int i = 63; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 8'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/bus_req_mux.sv
// Grant decoder: picks the owning master from the grant vector and selects its request fields.
module bus_req_mux
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int IDXW        = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic [NUM_MASTERS-1:0]            grant,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  input  logic [NUM_MASTERS-1:0]            m_we,
  output logic [IDXW-1:0]                   owner,
  output logic [ADDR_WIDTH-1:0]             sel_addr,
  output logic [DATA_WIDTH-1:0]             sel_wdata,
  output logic                              sel_we,
  output logic                              multi_hot
);

  // Owner decode, field selection and multi-hot detection
  always_comb begin
    owner     = IDXW'(onehot_to_idx(64'(grant)));
    sel_addr  = m_addr[owner*ADDR_WIDTH +: ADDR_WIDTH];
    sel_wdata = m_wdata[owner*DATA_WIDTH +: DATA_WIDTH];
    sel_we    = m_we[owner];
    multi_hot = ((grant & (grant - {{(NUM_MASTERS-1){1'b0}}, 1'b1})) != {NUM_MASTERS{1'b0}});
  end

endmodule

// File: rtl/bus_txn_controller.sv
// Runs one granted master's transaction on the shared slave bus with timeout abort;
// grants that cannot be taken are dropped and flagged.
module bus_txn_controller
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS    = DEF_NUM_MASTERS,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_MASTERS-1:0]            grant,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  input  logic [NUM_MASTERS-1:0]            m_we,
  output logic                              bus_valid,
  output logic [ADDR_WIDTH-1:0]             bus_addr,
  output logic [DATA_WIDTH-1:0]             bus_wdata,
  output logic                              bus_we,
  input  logic                              bus_ready,
  input  logic [DATA_WIDTH-1:0]             bus_rdata,
  input  logic                              bus_err,
  output logic [NUM_MASTERS-1:0]            done,
  output logic [NUM_MASTERS-1:0]            err,
  output logic [DATA_WIDTH-1:0]             rdata,
  output logic                              busy,
  output logic                              grant_drop
);

  localparam int IDXW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CTRW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CTRW-1:0]        CTR_ONE   = CTRW'(1'b1);
  localparam logic [CTRW-1:0]        CTR_LIMIT = CTRW'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_MASTERS-1:0] LSB_ONE   = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

  state_e                  state_q, state_d;
  logic [IDXW-1:0]         owner_q, owner_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    we_q, we_d;
  logic                    valid_q, valid_d;
  logic [CTRW-1:0]         ctr_q, ctr_d;
  logic [NUM_MASTERS-1:0]  done_q, done_d;
  logic [NUM_MASTERS-1:0]  err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    drop_q, drop_d;

  logic [IDXW-1:0]         sel_owner_s;
  logic [ADDR_WIDTH-1:0]   sel_addr_s;
  logic [DATA_WIDTH-1:0]   sel_wdata_s;
  logic                    sel_we_s;
  logic                    multi_hot_s;
  logic                    grant_any_s;

  bus_req_mux #(
    .NUM_MASTERS(NUM_MASTERS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IDXW       (IDXW)
  ) u_req_mux (
    .grant    (grant),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_we     (m_we),
    .owner    (sel_owner_s),
    .sel_addr (sel_addr_s),
    .sel_wdata(sel_wdata_s),
    .sel_we   (sel_we_s),
    .multi_hot(multi_hot_s)
  );

  assign grant_any_s = (grant != {NUM_MASTERS{1'b0}});

  // Next-state and next-output computation; response pulses default low so they last one cycle
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    valid_d = valid_q;
    ctr_d   = ctr_q;
    done_d  = {NUM_MASTERS{1'b0}};
    err_d   = {NUM_MASTERS{1'b0}};
    rdata_d = {DATA_WIDTH{1'b0}};
    drop_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_any_s) begin
          state_d = REQ;
          owner_d = sel_owner_s;
          addr_d  = sel_addr_s;
          wdata_d = sel_wdata_s;
          we_d    = sel_we_s;
          valid_d = 1'b1;
          ctr_d   = {CTRW{1'b0}};
          drop_d  = multi_hot_s;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        drop_d = grant_any_s;
        // Ready is checked first so that it beats a simultaneous timeout
        if (bus_ready) begin
          state_d = DONE;
          valid_d = 1'b0;
          done_d  = LSB_ONE << owner_q;
          err_d   = bus_err ? (LSB_ONE << owner_q) : {NUM_MASTERS{1'b0}};
          rdata_d = we_q ? {DATA_WIDTH{1'b0}} : bus_rdata;
        end else if (ctr_q == CTR_LIMIT) begin
          state_d = DONE;
          valid_d = 1'b0;
          done_d  = LSB_ONE << owner_q;
          err_d   = LSB_ONE << owner_q;
        end else begin
          ctr_d = ctr_q + CTR_ONE;
        end
      end
      DONE: begin
        drop_d  = grant_any_s;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= {IDXW{1'b0}};
      addr_q  <= {ADDR_WIDTH{1'b0}};
      wdata_q <= {DATA_WIDTH{1'b0}};
      we_q    <= 1'b0;
      valid_q <= 1'b0;
      ctr_q   <= {CTRW{1'b0}};
      done_q  <= {NUM_MASTERS{1'b0}};
      err_q   <= {NUM_MASTERS{1'b0}};
      rdata_q <= {DATA_WIDTH{1'b0}};
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      drop_q  <= drop_d;
    end
  end

  assign bus_valid  = valid_q;
  assign bus_addr   = addr_q;
  assign bus_wdata  = wdata_q;
  assign bus_we     = we_q;
  assign done       = done_q;
  assign err        = err_q;
  assign rdata      = rdata_q;
  assign busy       = (state_q == REQ) || (state_q == DONE);
  assign grant_drop = drop_q;

endmodule

// File: tb/tb_bus_txn_controller.sv
// Directed self-checking bench for bus_txn_controller: read, write, timeout, error, drops, reset.
module tb_bus_txn_controller;
  import bus_pkg::*;

  localparam int NM = 4;
  localparam int AW = 16;
  localparam int DW = 32;

  logic              clk;
  logic              reset_n;
  logic [NM-1:0]     grant;
  logic [NM*AW-1:0]  m_addr;
  logic [NM*DW-1:0]  m_wdata;
  logic [NM-1:0]     m_we;
  logic              bus_valid;
  logic [AW-1:0]     bus_addr;
  logic [DW-1:0]     bus_wdata;
  logic              bus_we;
  logic              bus_ready;
  logic [DW-1:0]     bus_rdata;
  logic              bus_err;
  logic [NM-1:0]     done;
  logic [NM-1:0]     err;
  logic [DW-1:0]     rdata;
  logic              busy;
  logic              grant_drop;

  int n_checks;
  int n_fail;
  int valid_cnt;

  bus_txn_controller #(
    .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .grant(grant), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_we(m_we), .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_err(bus_err),
    .done(done), .err(err), .rdata(rdata), .busy(busy), .grant_drop(grant_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance one edge and settle just after it; inputs set afterwards are seen at the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    grant     = 4'b0000;
    m_addr    = {16'h3333, 16'h1234, 16'h1111, 16'h0010};
    m_wdata   = {32'h33333333, 32'h22222222, 32'h11111111, 32'hA5A5A5A5};
    m_we      = 4'b0001;
    bus_ready = 1'b0;
    bus_rdata = 32'h0;
    bus_err   = 1'b0;
    tick();
    tick();
    check_eq("rst_valid", 64'(bus_valid), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_drop", 64'(grant_drop), 64'd0);
    reset_n = 1'b1;
    tick();

    // Read from master 2 with three wait cycles
    grant = 4'b0100;
    tick();
    check_eq("rd_valid", 64'(bus_valid), 64'd1);
    check_eq("rd_addr", 64'(bus_addr), 64'h1234);
    check_eq("rd_we", 64'(bus_we), 64'd0);
    check_eq("rd_busy", 64'(busy), 64'd1);
    grant = 4'b0000;
    m_addr[2*AW +: AW] = 16'hBEEF;
    tick();
    tick();
    tick();
    check_eq("rd_addr_hold", 64'(bus_addr), 64'h1234);
    check_eq("rd_wait_done", 64'(done), 64'd0);
    bus_ready = 1'b1;
    bus_rdata = 32'hCAFEF00D;
    tick();
    check_eq("rd_done", 64'(done), 64'h4);
    check_eq("rd_err", 64'(err), 64'h0);
    check_eq("rd_rdata", 64'(rdata), 64'hCAFEF00D);
    check_eq("rd_valid_low", 64'(bus_valid), 64'd0);
    bus_ready = 1'b0;
    tick();
    check_eq("rd_done_once", 64'(done), 64'h0);
    check_eq("rd_idle", 64'(busy), 64'd0);
    m_addr[2*AW +: AW] = 16'h1234;

    // Zero-wait write from master 0; rdata must read back 0
    grant     = 4'b0001;
    bus_ready = 1'b1;
    bus_rdata = 32'hDEADBEEF;
    tick();
    check_eq("wr_wdata", 64'(bus_wdata), 64'hA5A5A5A5);
    check_eq("wr_we", 64'(bus_we), 64'd1);
    check_eq("wr_addr", 64'(bus_addr), 64'h0010);
    grant = 4'b0000;
    tick();
    check_eq("wr_done", 64'(done), 64'h1);
    check_eq("wr_rdata", 64'(rdata), 64'h0);
    bus_ready = 1'b0;
    tick();

    // Timeout for master 1
    grant = 4'b0010;
    tick();
    grant = 4'b0000;
    valid_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus_valid) begin
        valid_cnt++;
        tick();
      end else begin
        break;
      end
    end
    check_eq("to_valid_cycles", 64'(valid_cnt), 64'd16);
    check_eq("to_done", 64'(done), 64'h2);
    check_eq("to_err", 64'(err), 64'h2);
    check_eq("to_rdata", 64'(rdata), 64'h0);
    tick();

    // Ready with slave error on the last allowed cycle: normal completion carrying rdata
    grant = 4'b0100;
    tick();
    grant = 4'b0000;
    for (int i = 0; i < 15; i++) tick();
    check_eq("lim_valid", 64'(bus_valid), 64'd1);
    bus_ready = 1'b1;
    bus_err   = 1'b1;
    bus_rdata = 32'h12345678;
    tick();
    check_eq("lim_done", 64'(done), 64'h4);
    check_eq("lim_err", 64'(err), 64'h4);
    check_eq("lim_rdata", 64'(rdata), 64'h12345678);
    bus_ready = 1'b0;
    bus_err   = 1'b0;
    tick();

    // Drops: grant during REQ, grant during DONE, multi-hot in IDLE
    grant = 4'b1000;
    tick();
    check_eq("dr_first_drop", 64'(grant_drop), 64'd0);
    check_eq("dr_addr3", 64'(bus_addr), 64'h3333);
    tick();
    check_eq("dr_req_drop", 64'(grant_drop), 64'd1);
    check_eq("dr_req_valid", 64'(bus_valid), 64'd1);
    grant = 4'b0000;
    bus_ready = 1'b1;
    tick();
    check_eq("dr_owner3", 64'(done), 64'h8);
    bus_ready = 1'b0;
    grant = 4'b0001;
    tick();
    check_eq("dr_done_drop", 64'(grant_drop), 64'd1);
    check_eq("dr_done_novalid", 64'(bus_valid), 64'd0);
    grant = 4'b0110;
    tick();
    check_eq("dr_multi_drop", 64'(grant_drop), 64'd1);
    check_eq("dr_multi_addr", 64'(bus_addr), 64'h1111);
    grant = 4'b0000;
    bus_ready = 1'b1;
    tick();
    check_eq("dr_multi_owner", 64'(done), 64'h2);
    bus_ready = 1'b0;
    tick();

    // Reset in the middle of a request
    grant = 4'b0100;
    tick();
    grant = 4'b0000;
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    check_eq("mr_valid", 64'(bus_valid), 64'd0);
    check_eq("mr_done", 64'(done), 64'h0);
    check_eq("mr_err", 64'(err), 64'h0);
    check_eq("mr_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    tick();
    check_eq("mr_still_idle", 64'(done | {3'b000, bus_valid}), 64'h0);
    grant = 4'b0001;
    tick();
    check_eq("mr_next_addr", 64'(bus_addr), 64'h0010);
    grant = 4'b0000;
    bus_ready = 1'b1;
    tick();
    check_eq("mr_next_done", 64'(done), 64'h1);
    bus_ready = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
